alu_muldiv: RTL and testbench

- Iterative multiply/divide companion to the combinational ALU. It implements the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) on DATA_WIDTH-bit operands.
- Uses a start/ready/done handshake, so the execute stage can stall while an operation runs.
- Multiply is a radix-2 shift-add; divide is a restoring divider. Both run on operand magnitudes, with sign correction in a final state.

---
 rtl/alu_muldiv.sv | 155 +++++++++++++++
 tb/tb_alu_muldiv.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider on operand magnitudes, with a start/ready/done handshake.

module alu_muldiv_step #(
  parameter int W = 32
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  output logic [2*W-1:0] nxt
);
  logic [W:0] sum;
  logic [W:0] rem_sh;
  logic [W:0] diff;

  // Multiply: acc = {partial_hi, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    sum    = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh = {acc[2*W-1:W], acc[W-1]};
    diff   = rem_sh - {1'b0, opnd};
    if (is_div)
      nxt = diff[W] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
                    : {diff[W-1:0],   acc[W-2:0], 1'b1};
    else
      nxt = {sum, acc[W-1:1]};
  end
endmodule

module alu_muldiv #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     start,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    ALUResult
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]  MIN      = {1'b1, {(W-1){1'b0}}};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]               state;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic [W-1:0]             a_q;
  logic [W-1:0]             opnd;
  logic [2*W-1:0]           acc;
  logic [2*W-1:0]           acc_nxt;
  logic [CW-1:0]            cnt;
  logic                     neg_q, rneg_q, divz_q, ovf_q;

  // Input decode for the accept cycle
  logic         dec_div, a_sgn, b_sgn, a_neg, b_neg, b_zero, dec_ovf;
  logic [W-1:0] a_mag, b_mag;

  always_comb begin
    dec_div = Operation[2];
    a_sgn   = dec_div ? ~Operation[0] : (Operation[1:0] == 2'b01 || Operation[1:0] == 2'b10);
    b_sgn   = dec_div ? ~Operation[0] : (Operation[1:0] == 2'b01);
    a_neg   = a_sgn & SrcA[W-1];
    b_neg   = b_sgn & SrcB[W-1];
    a_mag   = a_neg ? -SrcA : SrcA;
    b_mag   = b_neg ? -SrcB : SrcB;
    b_zero  = (SrcB == '0);
    dec_ovf = dec_div & ~Operation[0] & (SrcA == MIN) & (SrcB == '1);
  end

  alu_muldiv_step #(.W(W)) u_step (
    .is_div (op_q[2]),
    .acc    (acc),
    .opnd   (opnd),
    .nxt    (acc_nxt)
  );

  // Sign correction and result selection, registered in FINISH
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem, res;

  always_comb begin
    prod = neg_q  ? -acc : acc;
    quo  = neg_q  ? -acc[W-1:0] : acc[W-1:0];
    rem  = rneg_q ? -acc[2*W-1:W] : acc[2*W-1:W];
    if (!op_q[2])
      res = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    else if (divz_q)
      res = op_q[1] ? a_q : '1;
    else if (ovf_q)
      res = op_q[1] ? '0 : MIN;
    else
      res = op_q[1] ? rem : quo;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      opnd      <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      divz_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ALUResult <= '0;
    end else begin
      case (state)
        S_IDLE: if (start && !flush) begin
          op_q   <= Operation;
          a_q    <= SrcA;
          opnd   <= dec_div ? b_mag : a_mag;
          acc    <= {{W{1'b0}}, dec_div ? a_mag : b_mag};
          neg_q  <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          divz_q <= dec_div & b_zero;
          ovf_q  <= dec_ovf;
          cnt    <= '0;
          state  <= (dec_div && (b_zero || dec_ovf)) ? S_FINISH : S_RUN;
        end
        S_RUN: begin
          if (flush) state <= S_IDLE;
          else begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) state <= S_FINISH;
          end
        end
        S_FINISH: begin
          if (flush) state <= S_IDLE;
          else begin
            ALUResult <= res;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready = (state == S_IDLE);
  assign busy  = (state == S_RUN) || (state == S_FINISH);
  assign done  = (state == S_DONE);
endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised + directed bench for alu_muldiv with a cycle-accurate scoreboard
// built from an arithmetic reference model.

module tb_alu_muldiv;
  localparam int W = 32;
  localparam int NORM_LAT = W + 2;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic         clk = 1'b0, reset_n = 1'b1, flush = 1'b0, start = 1'b0;
  logic [2:0]   Operation = '0;
  logic [W-1:0] SrcA = '0, SrcB = '0;
  logic         ready, busy, done;
  logic [W-1:0] ALUResult;

  alu_muldiv #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .start(start),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
    .ready(ready), .busy(busy), .done(done), .ALUResult(ALUResult)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    int           acc;
    int           lat;
  } exp_t;

  exp_t         sbq[$];
  int           ncyc = 0;
  int           nvec = 0;
  int           nerr = 0;
  int           naccept = 0;
  bit           armed = 1'b0;
  logic [W-1:0] last_res = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == '0) return '1;
        if (a == MIN && b == '1) return MIN;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == '0) ? '1 : a / b;
      3'd6: begin
        if (b == '0) return a;
        if (a == MIN && b == '1) return '0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op[2] && (b == '0 || (!op[0] && a == MIN && b == '1))) return 2;
    return NORM_LAT;
  endfunction

  // Stimulus side: record accepted requests, drop ones killed by flush while busy
  always @(posedge clk) begin
    if (reset_n && armed) begin
      if (flush) begin
        if (sbq.size() > 0 && (ncyc - sbq[0].acc) < sbq[0].lat) sbq.delete(0);
      end else if (start && sbq.size() == 0) begin
        sbq.push_back('{res: ref_res(Operation, SrcA, SrcB), acc: ncyc,
                        lat: ref_lat(Operation, SrcA, SrcB)});
        naccept++;
      end
    end
  end

  // Monitor: per-cycle expectation of handshake outputs and result
  always @(negedge clk) begin
    bit exp_done, exp_busy;
    ncyc++;
    if (armed) begin
      if (sbq.size() > 0 && (ncyc - sbq[0].acc) > sbq[0].lat) sbq.delete(0);
      exp_done = sbq.size() > 0 && (ncyc - sbq[0].acc) == sbq[0].lat;
      exp_busy = sbq.size() > 0 && (ncyc - sbq[0].acc) <  sbq[0].lat;
      chk("ready", 32'(ready), 32'(sbq.size() == 0));
      chk("busy",  32'(busy),  32'(exp_busy));
      chk("done",  32'(done),  32'(exp_done));
      if (exp_done) begin
        chk("result", ALUResult, sbq[0].res);
        last_res = sbq[0].res;
      end else begin
        chk("hold", ALUResult, last_res);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (sbq.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL wait_idle: operation still pending after %0d cycles", n);
      sbq.delete();
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk); #1;
    start = 1'b1; Operation = op; SrcA = a; SrcB = b;
    @(negedge clk); #1;
    start = 1'b0; Operation = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp);
    issue(op, a, b);
    wait_idle();
    chk(name, ALUResult, exp);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return MIN;
      3: return 32'd1;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int budget;
    int target;
    #1 reset_n = 1'b0;
    #1 armed = 1'b1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_result", ALUResult, '0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    directed("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
    directed("mulh",   3'd1, MIN,          32'hFFFF_FFFF, 32'h0000_0000);
    directed("mulhsu", 3'd2, MIN,          32'hFFFF_FFFF, 32'h8000_0000);
    directed("mulhu",  3'd3, MIN,          32'hFFFF_FFFF, 32'h7FFF_FFFF);
    directed("div",    3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD);
    directed("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);
    directed("divu",   3'd5, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC);
    directed("remu",   3'd7, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001);
    directed("div_z",  3'd4, 32'd5,        32'd0,         32'hFFFF_FFFF);
    directed("remu_z", 3'd7, 32'd5,        32'd0,         32'd5);
    directed("div_ov", 3'd4, MIN,          32'hFFFF_FFFF, MIN);
    directed("rem_ov", 3'd6, MIN,          32'hFFFF_FFFF, 32'd0);

    // Abort mid-RUN: no done, previous result held
    issue(3'd5, 32'h1234_5678, 32'd3);
    repeat (10) @(negedge clk);
    #1 flush = 1'b1;
    @(negedge clk); #1 flush = 1'b0;
    chk("flush_ready", 32'(ready), 32'd1);
    chk("flush_hold", ALUResult, 32'd0);
    directed("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12);

    // flush overrides start in IDLE
    @(negedge clk); #1 start = 1'b1; flush = 1'b1; Operation = 3'd0; SrcA = 32'd9; SrcB = 32'd9;
    @(negedge clk); #1 start = 1'b0; flush = 1'b0;
    chk("flush_idle", 32'(busy), 32'd0);

    // flush during DONE does not cancel the completed result
    issue(3'd0, 32'd6, 32'd7);
    for (int i = 0; i < 60; i++) begin
      if (sbq.size() > 0 && (ncyc - sbq[0].acc) == sbq[0].lat) break;
      @(negedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk); #1 flush = 1'b0;
    wait_idle();
    chk("flush_done", ALUResult, 32'd42);

    // Reset mid-RUN
    issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0; sbq.delete(); last_res = '0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_busy",  32'(busy),  32'd0);
    chk("midrst_done",  32'(done),  32'd0);
    chk("midrst_result", ALUResult, '0);
    @(negedge clk); #2 reset_n = 1'b1;

    // Random phase: start mostly held high, operands change every cycle
    target = naccept + 1000;
    budget = 0;
    while (naccept < target && budget < 60000) begin
      @(negedge clk); #1;
      start     = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 299) == 0);
      Operation = 3'($urandom);
      SrcA      = pick();
      SrcB      = pick();
      budget++;
    end
    start = 1'b0; flush = 1'b0;
    if (naccept < target) begin
      nvec++; nerr++;
      $display("FAIL random_budget: %0d of 1000 accepted", 1000 - (target - naccept));
    end
    wait_idle();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
